uart_rx_os: RTL and testbench

Parametrised UART receiver that supersedes the fixed 8-bit strober-based receiver. It uses an oversampled bit clock with 3-sample majority voting at bit centre and false-start rejection. It supports configurable data width, optional odd/even parity and 1 or 2 stop bits, and reports framing and parity errors. It sits between the pad-side serial input and byte-stream consumers (FIFO, command decoder).

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_os.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the baud divider helper.
// Used by the oversampled receiver and the matching transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Clocks per oversample tick, truncated; zero means the clock is too slow.
    function automatic int unsigned calc_div(input int unsigned freq, input int unsigned baud,
                                             input int unsigned os);
        return freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, phase-reset by clear_i.
module uart_baud_tick #(
    parameter int unsigned DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == CW'(DIV - 1));
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: 3-tap majority vote at bit centre, false-start rejection,
// configurable data width, parity and stop bits, with framing/parity error reporting.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned FREQ       = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int unsigned DIV = calc_div(FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned C   = OVERSAMPLE / 2;
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam int unsigned IW  = $clog2(DATA_BITS);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_os: FREQ / (BAUD * OVERSAMPLE) must be at least 1");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_dbits
        $error("uart_rx_os: DATA_BITS must be 5..9");
    end
    if (PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
        $error("uart_rx_os: unsupported PARITY or STOP_BITS");
    end

    logic [1:0]           sync_q, sync_d;
    logic                 s_prev_q, s_prev_d;
    uart_state_e          state_q, state_d;
    logic [SW-1:0]        scnt_q, scnt_d, scnt_nxt;
    logic [1:0]           samp_q, samp_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop2_q, stop2_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic s_in, tick, start_edge, tap_lo, tap_mid, commit, wrap, maj, par_exp;

    assign s_in = sync_q[1];

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clear_i (start_edge),
        .tick_o  (tick)
    );

    always_comb begin
        sync_d     = {sync_q[0], in};
        s_prev_d   = s_in;
        start_edge = (state_q == StIdle) && !s_in && s_prev_q;

        // Taps are judged on the count the tick is about to produce, so tap C lands mid-bit.
        scnt_nxt = (scnt_q == SW'(OVERSAMPLE - 1)) ? '0 : scnt_q + 1'b1;
        tap_lo   = tick && (scnt_nxt == SW'(C - 1));
        tap_mid  = tick && (scnt_nxt == SW'(C));
        commit   = tick && (scnt_nxt == SW'(C + 1));
        wrap     = tick && (scnt_nxt == '0);
        maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & s_in) | (samp_q[1] & s_in);
        par_exp  = (^shreg_q) ^ (PARITY == PAR_ODD);

        state_d      = state_q;
        scnt_d       = tick ? scnt_nxt : scnt_q;
        samp_d       = samp_q;
        idx_d        = idx_q;
        stop2_d      = stop2_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        busy_d       = busy_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (tap_lo) samp_d[0] = s_in;
        if (tap_mid) samp_d[1] = s_in;

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d = StStart;
                    scnt_d  = '0;
                end
            end
            StStart: begin
                if (commit) begin
                    if (maj) begin
                        state_d = StIdle;
                    end else begin
                        busy_d  = 1'b1;
                        idx_d   = '0;
                        stop2_d = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end else if (busy_q && wrap) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (commit) begin
                    shreg_d[idx_q] = maj;
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (commit) begin
                    perr_d  = maj ^ par_exp;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (commit) begin
                    if (STOP_BITS == 2 && !stop2_q) begin
                        stop2_d = 1'b1;
                        ferr_d  = ferr_q | ~maj;
                    end else begin
                        // Leave half a bit early so a back-to-back start edge is caught.
                        valid_d      = 1'b1;
                        data_d       = shreg_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ferr_q | ~maj;
                        busy_d       = 1'b0;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= 2'b11;
            s_prev_q     <= 1'b1;
            state_q      <= StIdle;
            scnt_q       <= '0;
            samp_q       <= '0;
            idx_q        <= '0;
            stop2_q      <= 1'b0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            s_prev_q     <= s_prev_d;
            state_q      <= state_d;
            scnt_q       <= scnt_d;
            samp_q       <= samp_d;
            idx_q        <= idx_d;
            stop2_q      <= stop2_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 and a 7E2 receiver share one serial line;
// table-driven frames plus hand sequences for timing, glitches, drift and reset.
module tb_uart_rx_os;

    logic       clk;
    logic       reset_n;
    logic       line;
    logic [7:0] data8;
    logic       v8, b8, pe8, fe8;
    logic [6:0] data7;
    logic       v7, b7, pe7, fe7;

    int n_tests;
    int n_fail;
    int cyc;
    int t_send;

    // Monitor state, written only by the negedge monitor.
    logic [9:0] hist8[$];
    logic [8:0] hist7[$];
    int vcyc8, rise8, fall8, rises8;
    logic b8_prev;

    uart_rx_os #(
        .FREQ(3686400), .BAUD(115200), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .in(line), .data(data8), .valid(v8),
        .busy(b8), .parity_err(pe8), .frame_err(fe8)
    );

    uart_rx_os #(
        .FREQ(3686400), .BAUD(115200), .OVERSAMPLE(16),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) dut7 (
        .clk(clk), .reset_n(reset_n), .in(line), .data(data7), .valid(v7),
        .busy(b7), .parity_err(pe7), .frame_err(fe7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v8) begin
            hist8.push_back({pe8, fe8, data8});
            vcyc8 = cyc;
        end
        if (v7) hist7.push_back({pe7, fe7, data7});
        if (b8 && !b8_prev) begin
            rise8  = cyc;
            rises8 = rises8 + 1;
        end
        if (!b8 && b8_prev) fall8 = cyc;
        b8_prev = b8;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one frame, one line value per clock; per100 is the bit period in 1/100 clock.
    task automatic send(input logic [8:0] d, input int nb, input int par, input bit flip,
                        input int nstop, input bit stop_low, input int per100,
                        input bit inv_mid);
        logic [15:0] bits;
        logic        p;
        int          n;
        int          total;
        int          b;
        bits    = '1;
        bits[0] = 1'b0;
        p       = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bits[1 + i] = d[i];
            p = p ^ d[i];
        end
        n = 1 + nb;
        if (par != 0) begin
            bits[n] = ((par == 1) ? ~p : p) ^ flip;
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            bits[n] = !(stop_low && s == 0);
            n++;
        end
        total = (n * per100) / 100;
        for (int c = 0; c < total; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) t_send = cyc;
            b    = (c * 100) / per100;
            line = bits[b] ^ (inv_mid && (c % 32) == 16);
        end
        if (line !== 1'b1) begin
            @(posedge clk);
            #1 line = 1'b1;
        end
    endtask

    typedef struct {
        bit         sel;     // 0: 8N1 receiver, 1: 7E2 receiver
        logic [8:0] d;
        bit         flip;
        bit         stop_low;
        logic [8:0] exp_d;
        bit         exp_pe;
        bit         exp_fe;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] exp_last8;
    int         n0;
    int         r0;
    logic [9:0] h8;
    logic [8:0] h7;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        line    = 1'b1;
        reset_n = 1'b0;

        // 0x35 = 0110101b: four ones, so the even parity bit is 0.
        vecs[0] = '{0, 9'h0A5, 0, 0, 9'h0A5, 0, 0};
        vecs[1] = '{1, 9'h035, 0, 0, 9'h035, 0, 0};
        vecs[2] = '{1, 9'h035, 1, 0, 9'h035, 1, 0};
        vecs[3] = '{1, 9'h035, 0, 1, 9'h035, 0, 1};
        vecs[4] = '{0, 9'h03C, 0, 1, 9'h03C, 0, 1};
        vecs[5] = '{0, 9'h000, 0, 0, 9'h000, 0, 0};
        vecs[6] = '{0, 9'h03C, 0, 0, 9'h03C, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_data8", 32'(data8), 32'h0);
        check("reset_data7", 32'(data7), 32'h0);
        check("reset_flags8", 32'({v8, b8, pe8, fe8}), 32'h0);
        check("reset_flags7", 32'({v7, b7, pe7, fe7}), 32'h0);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);

        // 8N1 0xA5: nominal valid 306 clk after the line edge, plus pipeline slack.
        n0 = hist8.size();
        r0 = rises8;
        send(9'h0A5, 8, 0, 1'b0, 1, 1'b0, 3200, 1'b0);
        repeat (40) @(posedge clk);
        check("a5_count", 32'(hist8.size()), 32'(n0 + 1));
        if (hist8.size() > n0) check("a5_word", 32'(hist8[n0]), 32'h0A5);
        check("a5_latency", 32'(vcyc8 - t_send >= 303 && vcyc8 - t_send <= 315), 32'h1);
        check("a5_busy_once", 32'(rises8 - r0), 32'h1);
        check("a5_busy_rise", 32'(rise8 - t_send >= 10 && rise8 - t_send <= 40), 32'h1);
        check("a5_busy_fall", 32'(fall8), 32'(vcyc8));

        exp_last8 = 8'hA5;
        foreach (vecs[i]) begin
            if (vecs[i].sel) begin
                n0 = hist7.size();
                send(vecs[i].d, 7, 2, vecs[i].flip, 2, vecs[i].stop_low, 3200, 1'b0);
                repeat (60) @(posedge clk);
                check("vec7_count", 32'(hist7.size()), 32'(n0 + 1));
                h7 = (hist7.size() > 0) ? hist7[hist7.size() - 1] : 9'h1FF;
                check("vec7_data", 32'(h7[6:0]), 32'(vecs[i].exp_d));
                check("vec7_parity_err", 32'(h7[8]), 32'(vecs[i].exp_pe));
                check("vec7_frame_err", 32'(h7[7]), 32'(vecs[i].exp_fe));
            end else begin
                n0 = hist8.size();
                send(vecs[i].d, 8, 0, 1'b0, 1, vecs[i].stop_low, 3200, 1'b0);
                repeat (60) @(posedge clk);
                check("vec8_count", 32'(hist8.size()), 32'(n0 + 1));
                h8 = (hist8.size() > 0) ? hist8[hist8.size() - 1] : 10'h3FF;
                check("vec8_data", 32'(h8[7:0]), 32'(vecs[i].exp_d));
                check("vec8_parity_err", 32'(h8[9]), 32'(vecs[i].exp_pe));
                check("vec8_frame_err", 32'(h8[8]), 32'(vecs[i].exp_fe));
                exp_last8 = vecs[i].exp_d[7:0];
            end
            repeat (40) @(posedge clk);
        end

        // Low glitch of 3 ticks (6 clk): false start, nothing visible changes.
        n0 = hist8.size();
        r0 = rises8;
        @(posedge clk);
        #1 line = 1'b0;
        repeat (6) @(posedge clk);
        #1 line = 1'b1;
        repeat (60) @(posedge clk);
        check("glitch_no_valid", 32'(hist8.size()), 32'(n0));
        check("glitch_no_busy", 32'(rises8), 32'(r0));
        check("glitch_data_held", 32'(data8), 32'(exp_last8));

        // 0x81 with the centre tap of every bit inverted.
        n0 = hist8.size();
        send(9'h081, 8, 0, 1'b0, 1, 1'b0, 3200, 1'b1);
        repeat (60) @(posedge clk);
        check("tapinv_count", 32'(hist8.size()), 32'(n0 + 1));
        if (hist8.size() > n0) check("tapinv_word", 32'(hist8[n0]), 32'h081);
        repeat (400) @(posedge clk);

        // Back-to-back frames sent 3% fast.
        n0 = hist8.size();
        send(9'h000, 8, 0, 1'b0, 1, 1'b0, 3107, 1'b0);
        send(9'h0FF, 8, 0, 1'b0, 1, 1'b0, 3107, 1'b0);
        send(9'h055, 8, 0, 1'b0, 1, 1'b0, 3107, 1'b0);
        repeat (60) @(posedge clk);
        check("b2b_count", 32'(hist8.size()), 32'(n0 + 3));
        if (hist8.size() >= n0 + 3) begin
            check("b2b_word0", 32'(hist8[n0]), 32'h000);
            check("b2b_word1", 32'(hist8[n0 + 1]), 32'h0FF);
            check("b2b_word2", 32'(hist8[n0 + 2]), 32'h055);
        end
        repeat (400) @(posedge clk);

        // Reset mid data bit 4 (cycles 160..191 of the frame); trailing 1s cannot retrigger.
        n0 = hist8.size();
        fork
            send(9'h0FF, 8, 0, 1'b0, 1, 1'b0, 3200, 1'b0);
            begin
                repeat (177) @(posedge clk);
                #2;
                check("rst_busy_before", 32'(b8), 32'h1);
                #1 reset_n = 1'b0;
                #1;
                check("rst_busy_async", 32'(b8), 32'h0);
                check("rst_data_cleared", 32'(data8), 32'h0);
                repeat (3) @(posedge clk);
                #1 reset_n = 1'b1;
            end
        join
        repeat (60) @(posedge clk);
        check("rst_no_valid", 32'(hist8.size()), 32'(n0));
        send(9'h05A, 8, 0, 1'b0, 1, 1'b0, 3200, 1'b0);
        repeat (60) @(posedge clk);
        check("rst_after_count", 32'(hist8.size()), 32'(n0 + 1));
        if (hist8.size() > n0) check("rst_after_word", 32'(hist8[n0]), 32'h05A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no summary, expected finish");
        $fatal(1, "timeout");
    end

endmodule
